// File: rtl/hough_acc_arbiter.sv
// Hough accumulator arbiter: sole owner of the accumulator RAM port.
// Serializes three users of the single-port RAM:
//   - vote:  read-modify-write saturating increment of one rho bin
//   - read:  single-bin readout for the peak search
//   - clear: zero every bin 0..DEPTH-1 (automatically after reset, or on request)
// Ports:
//   clock, reset              - rising-edge clock, synchronous active-high reset
//   vote_valid/addr/ready     - vote handshake (addr is already-offset rho)
//   rd_valid/addr/ready       - readout handshake
//   rd_ack, rd_data           - one-cycle ack pulse, data held until next ack
//   clear_start, clear_busy   - clear request / clear pending-or-running
//   sat_flag, range_err       - sticky status, cleared when a clear begins
//   ram_addr/we/wdata/rdata   - accumulator RAM port (rdata one cycle after addr)
module hough_acc_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 1600,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vote_valid,
  input  logic [ADDR_W-1:0] vote_addr,
  output logic              vote_ready,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_ack,
  output logic [CNT_W-1:0]  rd_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              sat_flag,
  output logic              range_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CNT_W-1:0]  ram_wdata,
  input  logic [CNT_W-1:0]  ram_rdata
);

  typedef enum logic [2:0] {IDLE, CLEAR, V_RD, V_WR, R_RD, R_CAP} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_t            state;
  logic [ADDR_W-1:0] op_addr;
  logic [ADDR_W-1:0] clr_addr;
  logic              clear_pend;
  logic              last_grant_rd;   // 1: most recent accepted request was a read

  logic can_grant, grant_vote, grant_rd, vote_oor, rd_oor, rdata_max;
  logic [CNT_W-1:0] incr;

  // Ready is only offered from IDLE with no clear pending; on contention
  // the requester that did not win last time gets the slot.
  assign can_grant  = (state == IDLE) && !clear_pend;
  assign grant_vote = can_grant && vote_valid && (!rd_valid || last_grant_rd);
  assign grant_rd   = can_grant && rd_valid && (!vote_valid || !last_grant_rd);
  assign vote_ready = grant_vote;
  assign rd_ready   = grant_rd;

  assign vote_oor  = {1'b0, vote_addr} >= DEPTH_X;
  assign rd_oor    = {1'b0, rd_addr} >= DEPTH_X;
  assign rdata_max = (ram_rdata == CNT_MAX);
  assign incr      = rdata_max ? CNT_MAX : ram_rdata + CNT_W'(1);

  assign clear_busy = clear_pend || (state == CLEAR);

  // RAM port decoded from state. Held quiet during reset so an abandoned
  // read-modify-write can never land a write.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!reset) begin
      case (state)
        CLEAR: begin
          ram_addr = clr_addr;
          ram_we   = 1'b1;
        end
        V_RD, R_RD, R_CAP: ram_addr = op_addr;
        V_WR: begin
          ram_addr  = op_addr;
          ram_we    = 1'b1;
          ram_wdata = incr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      op_addr       <= '0;
      clr_addr      <= '0;
      clear_pend    <= 1'b1;
      last_grant_rd <= 1'b1;
      rd_ack        <= 1'b0;
      rd_data       <= '0;
      sat_flag      <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      rd_ack <= 1'b0;
      if (clear_start && state != CLEAR) clear_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clear_pend) begin
            // Entry drop wins over a same-cycle clear_start: one clear covers both.
            state      <= CLEAR;
            clear_pend <= 1'b0;
            clr_addr   <= '0;
            sat_flag   <= 1'b0;
            range_err  <= 1'b0;
          end else if (grant_vote) begin
            last_grant_rd <= 1'b0;
            if (vote_oor) range_err <= 1'b1;
            else begin
              op_addr <= vote_addr;
              state   <= V_RD;
            end
          end else if (grant_rd) begin
            last_grant_rd <= 1'b1;
            if (rd_oor) begin
              range_err <= 1'b1;
              rd_ack    <= 1'b1;
              rd_data   <= '0;
            end else begin
              op_addr <= rd_addr;
              state   <= R_RD;
            end
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == LAST_BIN) state <= IDLE;
        end
        V_RD: state <= V_WR;
        V_WR: begin
          if (rdata_max) sat_flag <= 1'b1;
          state <= IDLE;
        end
        R_RD: state <= R_CAP;
        R_CAP: begin
          rd_data <= ram_rdata;
          rd_ack  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hough_acc_arbiter.sv
// Self-checking bench for hough_acc_arbiter: behavioural RAM, per-bin
// reference counters and transaction-level expectations.
module tb_hough_acc_arbiter;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1600;
  localparam int CNT_W  = 16;
  localparam int CMAX   = 65535;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              vote_valid = 1'b0;
  logic [ADDR_W-1:0] vote_addr = '0;
  logic              vote_ready;
  logic              rd_valid = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic              rd_ack;
  logic [CNT_W-1:0]  rd_data;
  logic              clear_start = 1'b0;
  logic              clear_busy;
  logic              sat_flag;
  logic              range_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [CNT_W-1:0]  ram_wdata;
  logic [CNT_W-1:0]  ram_rdata;

  hough_acc_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .vote_valid(vote_valid), .vote_addr(vote_addr), .vote_ready(vote_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_ack(rd_ack), .rd_data(rd_data),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .sat_flag(sat_flag), .range_err(range_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM with a side port used only to preload bins.
  logic [CNT_W-1:0]  mem [0:(1<<ADDR_W)-1];
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [CNT_W-1:0]  pre_data = '0;
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: expected bin contents and sticky flags.
  int unsigned ref_bin [DEPTH];
  bit m_sat, m_rerr;
  int n_chk = 0, n_pass = 0;

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  // Sample/drive point: just after the falling edge.
  task automatic cyc();
    @(negedge clock); #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_bin[i] = 0;
    m_sat = 0;
    m_rerr = 0;
  endtask

  task automatic wait_clear();
    int n = 0, lw = -1, nw = 0, expa = 0;
    bit ok = 1;
    while (clear_busy && n < 4000) begin
      if (ram_we) begin
        if (int'(ram_addr) != expa || ram_wdata != 0 || (lw >= 0 && lw != n - 1)) ok = 0;
        expa++;
        lw = n;
        nw++;
      end
      cyc();
      n++;
    end
    model_clear();
    chk("clr_done", clear_busy, 0);
    chk("clr_seq", ok, 1);
    chk("clr_writes", nw, DEPTH);
    chk("clr_busy_fall", n, lw + 1);
    chk("clr_flags", {sat_flag, range_err}, 0);
  endtask

  task automatic do_vote(input int a);
    int n = 0;
    int unsigned e;
    vote_valid = 1'b1; vote_addr = ADDR_W'(a); #1;
    while (!vote_ready && n < 2000) begin cyc(); n++; end
    chk("vote_grant", vote_ready, 1);
    if (!vote_ready) begin vote_valid = 1'b0; return; end
    cyc();                                  // T+1
    if (a >= DEPTH) begin
      m_rerr = 1;
      chk("voor_ready", vote_ready, 1);
      chk("voor_we", ram_we, 0);
      chk("voor_rerr", range_err, 1);
      vote_valid = 1'b0;
    end else begin
      vote_valid = 1'b0;
      chk("vrd_we", ram_we, 0);
      chk("vrd_addr", ram_addr, a);
      e = sat_inc(ref_bin[a]);
      if (ref_bin[a] == CMAX) m_sat = 1;
      ref_bin[a] = e;
      cyc();                                // T+2
      chk("vwr_we", ram_we, 1);
      chk("vwr_addr", ram_addr, a);
      chk("vwr_wdata", ram_wdata, e);
      cyc();                                // T+3
      chk("vdone_we", ram_we, 0);
      chk("vote_sat", sat_flag, m_sat);
    end
  endtask

  task automatic do_read(input int a);
    int n = 0;
    rd_valid = 1'b1; rd_addr = ADDR_W'(a); #1;
    while (!rd_ready && n < 2000) begin cyc(); n++; end
    chk("rd_grant", rd_ready, 1);
    if (!rd_ready) begin rd_valid = 1'b0; return; end
    cyc();                                  // T+1
    rd_valid = 1'b0;
    if (a >= DEPTH) begin
      m_rerr = 1;
      chk("roor_ack", rd_ack, 1);
      chk("roor_data", rd_data, 0);
      chk("roor_rerr", range_err, 1);
      chk("roor_we", ram_we, 0);
      cyc();
      chk("roor_ack_end", rd_ack, 0);
    end else begin
      chk("rrd_addr", ram_addr, a);
      chk("rrd_we", ram_we, 0);
      chk("rrd_ack", rd_ack, 0);
      cyc();                                // T+2
      chk("rcap_ack", rd_ack, 0);
      cyc();                                // T+3
      chk("rd_ack", rd_ack, 1);
      chk("rd_data", rd_data, ref_bin[a]);
      cyc();
      chk("rd_ack_end", rd_ack, 0);
    end
  endtask

  initial begin
    int unsigned rq[$];
    int g, n, a;
    bit exp_vote;

    // Reset: requests are held off and everything reads idle.
    vote_valid = 1'b1; rd_valid = 1'b1;
    repeat (3) cyc();
    chk("rst_busy", clear_busy, 1);
    chk("rst_vready", vote_ready, 0);
    chk("rst_rready", rd_ready, 0);
    chk("rst_ack", rd_ack, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_flags", {sat_flag, range_err}, 0);
    chk("rst_ram", {ram_we, ram_addr, ram_wdata}, 0);
    vote_valid = 1'b0; rd_valid = 1'b0;
    reset = 1'b0;
    wait_clear();
    vote_valid = 1'b1; #1;
    chk("post_clr_vready", vote_ready, 1);
    vote_valid = 1'b0; #1;

    // Contention: both held high, grants alternate starting with vote.
    vote_addr = 11'd100; rd_addr = 11'd100;
    vote_valid = 1'b1; rd_valid = 1'b1; #1;
    g = 0; n = 0; exp_vote = 1;
    while (g < 6 && n < 200) begin
      if (rd_ack) begin
        chk("alt_rq", rq.size() > 0, 1);
        if (rq.size() > 0) chk("alt_rdata", rd_data, rq.pop_front());
      end
      if (vote_ready || rd_ready) begin
        chk("alt_vote", vote_ready, exp_vote);
        chk("alt_rd", rd_ready, !exp_vote);
        if (vote_ready) ref_bin[100] = sat_inc(ref_bin[100]);
        else rq.push_back(ref_bin[100]);
        exp_vote = !exp_vote;
        g++;
      end
      cyc();
      n++;
    end
    vote_valid = 1'b0; rd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (rd_ack && rq.size() > 0) chk("alt_rdata", rd_data, rq.pop_front());
      cyc();
    end
    chk("alt_grants", g, 6);
    chk("alt_drained", rq.size(), 0);

    // Three votes then a read of the same bin.
    repeat (3) do_vote(800);
    do_read(800);

    // Saturation, then a clear drops the sticky flag.
    pre_we = 1'b1; pre_addr = 11'd5; pre_data = 16'hFFFF;
    cyc();
    pre_we = 1'b0;
    ref_bin[5] = CMAX;
    do_vote(5);
    chk("sat_set", sat_flag, 1);
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    wait_clear();

    // Out-of-range vote and read.
    do_vote(1700);
    do_read(1650);

    // Randomized mix against the reference model.
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 2047)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) do_vote(a);
      else do_read(a);
      chk("rnd_rerr", range_err, m_rerr);
      chk("rnd_sat", sat_flag, m_sat);
    end

    // Clear requested mid-RMW: the write completes, then the clear runs;
    // a read held during the clear is served afterwards.
    do_vote(10);
    vote_valid = 1'b1; vote_addr = 11'd10; #1;
    n = 0;
    while (!vote_ready && n < 100) begin cyc(); n++; end
    chk("mid_grant", vote_ready, 1);
    cyc();                                  // V_RD
    vote_valid = 1'b0;
    clear_start = 1'b1;
    chk("mid_vrd_addr", ram_addr, 10);
    cyc();                                  // V_WR
    clear_start = 1'b0;
    chk("mid_vwr_we", ram_we, 1);
    chk("mid_vwr_addr", ram_addr, 10);
    chk("mid_vwr_wdata", ram_wdata, sat_inc(ref_bin[10]));
    chk("mid_busy", clear_busy, 1);
    cyc();                                  // IDLE with clear pending
    rd_valid = 1'b1; rd_addr = 11'd10; #1;
    chk("mid_idle_we", ram_we, 0);
    chk("mid_hold_rready", rd_ready, 0);
    wait_clear();
    chk("held_rready", rd_ready, 1);
    cyc();
    rd_valid = 1'b0;
    cyc();
    cyc();
    chk("held_ack", rd_ack, 1);
    chk("held_data", rd_data, 0);

    // Reset in V_RD abandons the RMW with no write.
    do_vote(20);
    vote_valid = 1'b1; vote_addr = 11'd20; #1;
    n = 0;
    while (!vote_ready && n < 100) begin cyc(); n++; end
    cyc();                                  // V_RD
    vote_valid = 1'b0;
    reset = 1'b1;
    cyc();
    chk("rst_mid_we", ram_we, 0);
    chk("rst_mid_busy", clear_busy, 1);
    reset = 1'b0;
    wait_clear();
    do_read(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
